// File: rtl/line_buf_ctrl.sv
// Write/read sequencer for a 4-entry line-buffer ring feeding a 3-row window engine.
// Write side follows the raster input; read side rotates the base row once per streamed row.
module line_buf_ctrl #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    localparam int COL_W = $clog2(IMG_W),
    localparam int ROW_W = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             wr_en,
    output logic [1:0]       wr_sel,
    output logic [COL_W-1:0] wr_addr,
    output logic [1:0]       base,
    output logic [COL_W-1:0] rd_addr,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             win_last,
    output logic             busy,
    output logic             frame_done
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_FILL  | writing rows 0..2, no window output
    // S_STREAM| rows 3..IMG_H-1, write and window beat move together
    // S_DRAIN | last window row from stored lines, no writes
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DRAIN} state_t;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] FILL_LAST = ROW_W'(2);

    state_t           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [1:0]       base_q;
    logic             done_q;

    logic xfer;
    logic col_end;

    always_comb begin
        pix_ready = (state_q == S_FILL) | ((state_q == S_STREAM) & win_ready);
        win_valid = ((state_q == S_STREAM) & pix_valid) | (state_q == S_DRAIN);
        wr_en     = pix_valid & pix_ready;
        xfer      = (state_q == S_DRAIN) ? win_ready : wr_en;
        col_end   = (col_q == COL_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FILL;
                        col_q   <= '0;
                        row_q   <= '0;
                        base_q  <= '0;
                    end
                end
                S_FILL: begin
                    if (xfer) begin
                        if (col_end) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                            if (row_q == FILL_LAST) state_q <= S_STREAM;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        if (col_end) begin
                            col_q  <= '0;
                            base_q <= base_q + 2'd1;
                            // Row counter stays on the last row so it never wraps in DRAIN.
                            if (row_q == ROW_LAST) state_q <= S_DRAIN;
                            else                   row_q   <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        if (col_end) begin
                            col_q   <= '0;
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_sel     = row_q[1:0];
    assign wr_addr    = col_q;
    assign rd_addr    = col_q;
    assign base       = base_q;
    assign win_last   = (state_q == S_DRAIN) & col_end;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Scoreboard bench for line_buf_ctrl at IMG_W=4, IMG_H=8: expected write and window
// beats are queued per frame and popped as the DUT produces them.
module tb_line_buf_ctrl;
    localparam int W = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pix_valid;
    logic       pix_ready;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [1:0] wr_addr;
    logic [1:0] base;
    logic [1:0] rd_addr;
    logic       win_valid;
    logic       win_ready;
    logic       win_last;
    logic       busy;
    logic       frame_done;

    line_buf_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .base(base), .rd_addr(rd_addr),
        .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int expw[$];
    int expb[$];
    int wcnt, bcnt;
    bit done_pending, done_seen, stall_chk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference ordering: write (row mod 4, col) for every pixel; window beat
    // (base, col, last) for rows 3..H-1 plus one drain row.
    task automatic push_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                expw.push_back((r % 4) * 256 + c);
        for (int r = 3; r <= H; r++)
            for (int c = 0; c < W; c++)
                expb.push_back(((r - 3) % 4) * 256 + c * 2 + ((r == H && c == W - 1) ? 1 : 0));
    endtask

    task automatic tick();
        int e;
        @(negedge clk);
        chk("frame_done", int'(frame_done), int'(done_pending));
        done_pending = 0;
        if (frame_done) done_seen = 1;
        if (stall_chk) begin
            chk("stall_pix_ready", int'(pix_ready), 0);
            chk("stall_wr_en", int'(wr_en), 0);
            chk("stall_col", int'(wr_addr), 2);
            chk("stall_win_valid", int'(win_valid), 1);
        end
        if (wr_en) begin
            chk("wr_q_nonempty", (expw.size() > 0) ? 1 : 0, 1);
            if (expw.size() > 0) begin
                e = expw.pop_front();
                chk("write_sel_addr", int'(wr_sel) * 256 + int'(wr_addr), e);
            end
        end
        if (win_valid && win_ready) begin
            chk("fill_gate", (wcnt >= 3 * W) ? 1 : 0, 1);
            chk("win_q_nonempty", (expb.size() > 0) ? 1 : 0, 1);
            if (expb.size() > 0) begin
                e = expb.pop_front();
                chk("win_base_addr_last",
                    int'(base) * 256 + int'(rd_addr) * 2 + int'(win_last), e);
            end
            bcnt++;
            if (win_last) done_pending = 1;
        end
        if (wr_en) wcnt++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: full rate; 1: pix_valid toggles + stray start; 2: window stall at row 3 col 2; 3: random
    task automatic run_frame(input int mode, input bit chain, input bit started, input int abort);
        int stall_cnt = 0;
        push_frame();
        wcnt = 0; bcnt = 0; done_seen = 0;
        if (!started) begin
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done_seen && (abort == 0 || wcnt < abort); cyc++) begin
            start = 1'b0;
            stall_chk = 0;
            pix_valid = 1'b1;
            win_ready = 1'b1;
            case (mode)
                1: begin
                    pix_valid = (cyc % 2 == 1);
                    if (cyc == 5) start = 1'b1;
                end
                2: if (wcnt == 3 * W + 2 && stall_cnt < 3) begin
                    win_ready = 1'b0;
                    stall_chk = 1;
                    stall_cnt++;
                end
                3: begin
                    pix_valid = 1'($urandom_range(0, 1));
                    win_ready = 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            if (chain && done_pending) start = 1'b1;
            tick();
        end
        start = 1'b0;
        stall_chk = 0;
        if (abort == 0) begin
            chk("done_seen", int'(done_seen), 1);
            chk("write_count", wcnt, W * H);
            chk("beat_count", bcnt, W * (H - 2));
            chk("wr_q_empty", expw.size(), 0);
            chk("win_q_empty", expb.size(), 0);
            chk("busy_after_frame", int'(busy), chain ? 1 : 0);
            if (mode == 2) chk("stall_cycles", stall_cnt, 3);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0;
        done_pending = 0; done_seen = 0; stall_chk = 0; wcnt = 0; bcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_base", int'(base), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        tick();

        run_frame(0, 0, 0, 0);
        run_frame(1, 0, 0, 0);
        run_frame(2, 0, 0, 0);
        run_frame(0, 1, 0, 0);
        run_frame(0, 0, 1, 0);
        run_frame(3, 0, 0, 0);

        // Abort at row 5 col 1 (base 2) and reset asynchronously.
        run_frame(0, 0, 0, 5 * W + 1);
        chk("pre_rst_base", int'(base), 2);
        chk("pre_rst_win_valid", int'(win_valid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pix_ready", int'(pix_ready), 0);
        chk("midrst_win_valid", int'(win_valid), 0);
        chk("midrst_base", int'(base), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expw.delete();
        expb.delete();
        done_pending = 0;
        tick();
        run_frame(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
